embertrail_issue_seq: RTL

- Parametrised issue sequencer for the Embertrail dual-lane core. Replaces the free-running PC update with a state machine.
- Fetches a 32-bit instruction packet and issues lane 1 and lane 2.
- Serialises data-memory accesses from both lanes over a ready handshake.
- Owns the hardware stack pointer for PUSH/POP, resolves BEQ branches, and traps stack and memory faults.
- Sits between the instruction memory and the datapath decode/ALU/register-file logic.

---
 rtl/embertrail_issue_seq_if.sv | 67 ++++++
 rtl/embertrail_issue_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/embertrail_issue_seq_if.sv
// -----------------------------------------------------------------------------
// embertrail_issue_seq_if
// Bundles the fetch, issue and data-memory signals of the Embertrail issue
// sequencer so the core and its environment connect through one port.
//
// Signals (named from the sequencer's point of view):
//   iIR[31:0]      instruction packet: lane1 op [3:0], dual [15],
//                  lane2 op [19:16], extended address [31:16]
//   iIRValid       iIR holds a packet this cycle
//   iCmpResult     lane-1 compare result, used only by BEQ
//   iMemReady      data memory completes the current access
//   oInstAddrBus   fetch address (PC)
//   oFetchReq      fetch request
//   oIssue1/2      one-cycle lane issue strobes
//   oMemReq        data memory request
//   oMemWrite      1 = write (STR/PUSH), 0 = read (LDR/POP)
//   oMemLane       0 = lane 1, 1 = lane 2 owns the access
//   oMemUseSP      the address comes from the stack path
//   oStackAddr     stack address of the current stack access
//   oSP            current stack pointer
//   oFault         sticky fault flag
//   oFaultCode     01 overflow, 10 underflow, 11 memory timeout
//   oDbgState      sequencer state, for observation only
//
// Handshake: once oMemReq rises, oMemWrite, oMemLane, oMemUseSP and
// oStackAddr stay stable until a cycle in which oMemReq and iMemReady are both
// 1; that clock edge completes the access. A fetch completes on the edge where
// oFetchReq and iIRValid are both 1.
// -----------------------------------------------------------------------------
interface embertrail_issue_seq_if #(
   parameter int PC_W = 16,
   parameter int SP_W = 16
);
   logic [31:0]     iIR;
   logic            iIRValid;
   logic            iCmpResult;
   logic            iMemReady;
   logic [PC_W-1:0] oInstAddrBus;
   logic            oFetchReq;
   logic            oIssue1;
   logic            oIssue2;
   logic            oMemReq;
   logic            oMemWrite;
   logic            oMemLane;
   logic            oMemUseSP;
   logic [SP_W-1:0] oStackAddr;
   logic [SP_W-1:0] oSP;
   logic            oFault;
   logic [1:0]      oFaultCode;
   logic [2:0]      oDbgState;

   // Sequencer side.
   modport master (
      input  iIR, iIRValid, iCmpResult, iMemReady,
      output oInstAddrBus, oFetchReq, oIssue1, oIssue2, oMemReq, oMemWrite,
             oMemLane, oMemUseSP, oStackAddr, oSP, oFault, oFaultCode,
             oDbgState
   );

   // Instruction memory / data memory / datapath side.
   modport slave (
      output iIR, iIRValid, iCmpResult, iMemReady,
      input  oInstAddrBus, oFetchReq, oIssue1, oIssue2, oMemReq, oMemWrite,
             oMemLane, oMemUseSP, oStackAddr, oSP, oFault, oFaultCode,
             oDbgState
   );
endinterface

// File: rtl/embertrail_issue_seq.sv
// -----------------------------------------------------------------------------
// embertrail_issue_seq
// Issue sequencer for the Embertrail dual-lane core. Fetches a packet, issues
// lane 1 and (when dual and not extended) lane 2, serialises the memory
// accesses of both lanes, owns the hardware stack pointer, resolves BEQ and
// traps stack overflow/underflow and memory timeouts.
//
// Ports:
//   iClock    clock
//   iReset_n  asynchronous active-low reset
//   bus       embertrail_issue_seq_if.master (fetch, issue, memory, status)
//
// All outputs come straight from flops; the strobe/request flops are loaded
// from the next-state values so they line up with the state register.
// -----------------------------------------------------------------------------
module embertrail_issue_seq #(
   parameter int              PC_W        = 16,
   parameter int              SP_W        = 16,
   parameter logic [SP_W-1:0] SP_TOP      = 16'hFFFF,
   parameter int              STACK_DEPTH = 64,
   parameter int              WAIT_MAX    = 15
) (
   input logic                    iClock,
   input logic                    iReset_n,
   embertrail_issue_seq_if.master bus
);

   localparam int              CNT_W   = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
   localparam logic [SP_W-1:0] SP_FULL = SP_TOP - SP_W'(STACK_DEPTH);

   localparam logic [3:0] OP_LDR  = 4'b0111;
   localparam logic [3:0] OP_LDA  = 4'b1000;
   localparam logic [3:0] OP_STR  = 4'b1001;
   localparam logic [3:0] OP_PUSH = 4'b1010;
   localparam logic [3:0] OP_POP  = 4'b1011;
   localparam logic [3:0] OP_BEQ  = 4'b1100;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_ISSUE = 3'd1,
      ST_MEM1  = 3'd2,
      ST_MEM2  = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   function automatic logic is_mem(input logic [3:0] op);
      return (op == OP_LDR) || (op == OP_STR) || (op == OP_PUSH) || (op == OP_POP);
   endfunction

   function automatic logic is_ext(input logic [3:0] op);
      return (op == OP_LDA) || (op == OP_BEQ);
   endfunction

   // Architectural state
   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [SP_W-1:0]  sp_q, sp_d;
   logic [31:0]      ir_q, ir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic [1:0]       code_q, code_d;

   // Registered outputs
   logic             fetch_req_q, fetch_req_d;
   logic             issue1_q, issue1_d;
   logic             issue2_q, issue2_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_write_q, mem_write_d;
   logic             mem_lane_q, mem_lane_d;
   logic             use_sp_q, use_sp_d;
   logic [SP_W-1:0]  stack_addr_q, stack_addr_d;

   // Decode of the captured packet
   logic [3:0] op1_q, op2_q, cur_op_q;
   logic       dual_q, ext_q, lane2_mem_q;

   assign op1_q       = ir_q[3:0];
   assign op2_q       = ir_q[19:16];
   assign dual_q      = ir_q[15];
   assign ext_q       = is_ext(op1_q);
   assign lane2_mem_q = dual_q & ~ext_q & is_mem(op2_q);
   assign cur_op_q    = (state_q == ST_MEM2) ? op2_q : op1_q;

   // Sequencing helpers
   logic       enter, enter_lane2, finish;
   logic [3:0] enter_op;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      sp_d        = sp_q;
      ir_d        = ir_q;
      cnt_d       = cnt_q;
      fault_d     = fault_q;
      code_d      = code_q;
      enter       = 1'b0;
      enter_lane2 = 1'b0;
      finish      = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            if (bus.iIRValid) begin
               ir_d    = bus.iIR;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (is_mem(op1_q)) begin
               enter = 1'b1;
            end else if (lane2_mem_q) begin
               enter       = 1'b1;
               enter_lane2 = 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         ST_MEM1, ST_MEM2: begin
            if (bus.iMemReady) begin
               cnt_d = '0;
               if (cur_op_q == OP_PUSH) begin
                  sp_d = sp_q - SP_W'(1);
               end else if (cur_op_q == OP_POP) begin
                  sp_d = sp_q + SP_W'(1);
               end
               if ((state_q == ST_MEM1) && lane2_mem_q) begin
                  enter       = 1'b1;
                  enter_lane2 = 1'b1;
               end else begin
                  finish = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_MAX) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
                  code_d  = 2'b11;
               end
            end
         end
         ST_FAULT: begin
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase

      // The stack check uses sp_d so a lane-2 access sees lane 1's update.
      enter_op = enter_lane2 ? op2_q : op1_q;
      if (enter) begin
         if ((enter_op == OP_PUSH) && (sp_d == SP_FULL)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = 2'b01;
         end else if ((enter_op == OP_POP) && (sp_d == SP_TOP)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = 2'b10;
         end else begin
            state_d = enter_lane2 ? ST_MEM2 : ST_MEM1;
         end
      end

      // BEQ is never a memory op and suppresses lane 2, so a taken branch
      // always finishes straight out of ISSUE where iCmpResult is sampled.
      if (finish) begin
         if ((state_q == ST_ISSUE) && (op1_q == OP_BEQ) && bus.iCmpResult) begin
            pc_d = PC_W'(ir_q[31:16]);
         end else begin
            pc_d = pc_q + ((dual_q | ext_q) ? PC_W'(2) : PC_W'(1));
         end
         state_d = ST_FETCH;
      end
   end

   // Output values for the cycle after this edge, taken from next state.
   logic [3:0] out_op;

   always_comb begin
      out_op       = (state_d == ST_MEM2) ? ir_d[19:16] : ir_d[3:0];
      fetch_req_d  = (state_d == ST_FETCH);
      issue1_d     = (state_d == ST_ISSUE);
      issue2_d     = (state_d == ST_ISSUE) & ir_d[15] & ~is_ext(ir_d[3:0]);
      mem_req_d    = (state_d == ST_MEM1) || (state_d == ST_MEM2);
      mem_lane_d   = (state_d == ST_MEM2);
      mem_write_d  = mem_req_d & ((out_op == OP_STR) || (out_op == OP_PUSH));
      use_sp_d     = mem_req_d & ((out_op == OP_PUSH) || (out_op == OP_POP));
      stack_addr_d = (out_op == OP_PUSH) ? (sp_d - SP_W'(1)) : sp_d;
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q      <= ST_FETCH;
         pc_q         <= '0;
         sp_q         <= SP_TOP;
         ir_q         <= '0;
         cnt_q        <= '0;
         fault_q      <= 1'b0;
         code_q       <= 2'b00;
         fetch_req_q  <= 1'b1;
         issue1_q     <= 1'b0;
         issue2_q     <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_lane_q   <= 1'b0;
         use_sp_q     <= 1'b0;
         stack_addr_q <= SP_TOP;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         sp_q         <= sp_d;
         ir_q         <= ir_d;
         cnt_q        <= cnt_d;
         fault_q      <= fault_d;
         code_q       <= code_d;
         fetch_req_q  <= fetch_req_d;
         issue1_q     <= issue1_d;
         issue2_q     <= issue2_d;
         mem_req_q    <= mem_req_d;
         mem_write_q  <= mem_write_d;
         mem_lane_q   <= mem_lane_d;
         use_sp_q     <= use_sp_d;
         stack_addr_q <= stack_addr_d;
      end
   end

   assign bus.oInstAddrBus = pc_q;
   assign bus.oFetchReq    = fetch_req_q;
   assign bus.oIssue1      = issue1_q;
   assign bus.oIssue2      = issue2_q;
   assign bus.oMemReq      = mem_req_q;
   assign bus.oMemWrite    = mem_write_q;
   assign bus.oMemLane     = mem_lane_q;
   assign bus.oMemUseSP    = use_sp_q;
   assign bus.oStackAddr   = stack_addr_q;
   assign bus.oSP          = sp_q;
   assign bus.oFault       = fault_q;
   assign bus.oFaultCode   = code_q;
   assign bus.oDbgState    = state_q;

endmodule
